sdram_responder: RTL
====================

Name: sdram_responder

Overview:
- Synthesizable SDRAM device emulator: the chip-side end of the MT48LC16M16-style command bus driven by the core SDRAM controller.
- Decodes ACTIVE/READ/WRITE/PRECHARGE/AUTO_REFRESH/LOAD_MODE/BURST_TERMINATE, tracks per-bank open rows and the mode register, and serves data from internal block RAM with CAS-latency timing.
- Used as the controller's simulation/FPGA-loopback target. Flags protocol violations in sticky error bits.

Parameters:
- ROW_BITS, 4, row bits stored internally; upper row address bits are ignored.
- COL_BITS, 5, column bits stored internally; upper column bits are ignored.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cke  in  1  clock enable; low = every command treated as INHIBIT
- ncs, nras, ncas, nwe  in  1 each  command bus
- ba  in  2  bank address
- a  in  13  row/column/mode address
- dqml, dqmh  in  1 each  write byte masks (1 = masked)
- dq_in  in  16  write data
- dq_out  out  16  read data
- dq_oe  out  1  read-data drive enable
- err  out  5  sticky protocol error flags
- refresh_cnt  out  16  AUTO_REFRESH count, wraps

Behaviour:
- Reset: mode_valid=0, all banks idle, burst inactive, dq_oe=0, dq_out=0, err=0, refresh_cnt=0. Memory contents are not cleared.
- Decode {ncs,nras,ncas,nwe} on cke=1 only:
  - 1xxx/0111 = NOP
  - 0011 = ACTIVE
  - 0101 = READ
  - 0100 = WRITE
  - 0110 = BURST_TERMINATE
  - 0010 = PRECHARGE
  - 0001 = AUTO_REFRESH
  - 0000 = LOAD_MODE
- LOAD_MODE: latch a[9:0] and set mode_valid.
  - CL=a[6:4], BL=a[2:0], type=a[3], write-burst-single=a[9].
  - Supported: CL 2 or 3; BL 0..3 (burst of 1/2/4/8); sequential type. Anything else sets err[3]; the mode is still stored and treated as CL=2, BL=1.
  - Any bank open at LOAD_MODE also sets err[0].
- ACTIVE: bank ba becomes open with row a[ROW_BITS-1:0]; its per-bank tRCD counter loads TRCD-1. ACTIVE to an already-open bank sets err[0]; the row is reloaded.
- READ/WRITE: column = a[COL_BITS-1:0]; bank ba.
  - Bank idle sets err[1]; the command is ignored.
  - tRCD counter nonzero sets err[4]; the access proceeds.
  - Any command other than NOP before mode_valid sets err[2] and is ignored, except LOAD_MODE and PRECHARGE.
  - a[10]=1 (auto-precharge) closes the bank after the burst.
- Memory address = {ba, row, col}; depth 4·2^ROW_BITS·2^COL_BITS words of 16 bits.
- Read timing: READ sampled at edge E. Beat k drives dq_out/dq_oe from edge E+CL-1+k, so it is stable at edge E+CL+k.
  - Burst column wraps within the BL-aligned block: col[2:0] increments mod BL.
  - dq_oe falls after the last beat.
- A READ during an active read burst truncates it; the new burst follows at its own CL.
- WRITE or BURST_TERMINATE during a read burst: no further beats are issued after that edge; beats already in the CL pipeline still drive.
- Write: WRITE at edge E stores dq_in with byte enables ~dqmh/~dqml at E.
  - If BL>1 and write-burst-single=0: subsequent beats are taken from dq_in on edges E+1.. with wrapping columns.
  - Any new command ends a write burst.
- PRECHARGE: a[10]=1 closes all banks; otherwise closes bank ba. Precharge of an idle bank is legal.
- AUTO_REFRESH: refresh_cnt+1. Any bank open sets err[0].
- Simultaneous events: a new command on the same edge as a burst's final beat is decoded normally. Reset mid-burst aborts it and dq_oe=0 on the next edge.
- cke=0: commands ignored; burst and CL pipelines keep advancing.

Decomposition:
- Package sdram_pkg: CMD_* 4-bit encodings, mode-register field positions, err bit indices (ERR_BANK_STATE=0, ERR_IDLE_ACCESS=1, ERR_NO_MODE=2, ERR_BAD_MODE=3, ERR_TRCD=4). Shared with the controller.
- Sub-module sdram_resp_bank: per-bank open flag, row register, tRCD down-counter, auto-precharge-pending bit. Instantiated ×4.

Test Plan:
- LOAD_MODE a=0x220 (CL2, BL1, single write), ACTIVE ba=1 row 3, wait 2, WRITE col 5 dq_in=0xA55A, dqm=00, READ col 5 → dq_oe high for exactly 1 beat, 0xA55A stable at the 2nd edge after READ; err=0.
- Write 0x1234 at col 6, then WRITE 0xFFFF with dqmh=1 → read returns 0x12FF.
- Mode CL3 BL4 (a=0x032), preload cols 4..7 = 1..4, READ col 6 → beats 3,4,1,2 at edges E+3..E+6.
- READ with no open bank → err[1]=1, dq_oe stays 0. READ one cycle after ACTIVE → err[4]=1, data still returned.
- AUTO_REFRESH ×3 with all banks precharged (a[10]=1) → refresh_cnt=3, err=0. AUTO_REFRESH with a bank open → err[0]=1.
- Reset asserted during a BL8 read at beat 3 → dq_oe=0 on next edge, err=0, refresh_cnt=0; ACTIVE before LOAD_MODE → err[2]=1.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command-bus encodings, mode-register layout and error bit indices.
// The controller and the device emulator both use these definitions.
package sdram_pkg;

  // {ncs, nras, ncas, nwe}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_BST       = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  localparam int MODE_BL_LSB   = 0;
  localparam int MODE_TYPE_BIT = 3;
  localparam int MODE_CL_LSB   = 4;
  localparam int MODE_WBS_BIT  = 9;

  localparam int ERR_BANK_STATE  = 0;
  localparam int ERR_IDLE_ACCESS = 1;
  localparam int ERR_NO_MODE     = 2;
  localparam int ERR_BAD_MODE    = 3;
  localparam int ERR_TRCD        = 4;
  localparam int ERR_W           = 5;

  function automatic logic mode_supported(input logic [9:0] m);
    logic [2:0] cl;
    logic [2:0] bl;
    cl = m[MODE_CL_LSB +: 3];
    bl = m[MODE_BL_LSB +: 3];
    return (cl == 3'd2 || cl == 3'd3) && (bl <= 3'd3) && !m[MODE_TYPE_BIT];
  endfunction

  // Burst length minus one, which doubles as the column wrap mask.
  function automatic logic [2:0] bl_mask(input logic [2:0] bl);
    case (bl)
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      3'd3:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// One SDRAM bank's state: open flag, open row, tRCD countdown and a pending
// auto-precharge that closes the bank when its burst ends.
module sdram_resp_bank #(
  parameter int ROW_BITS = 4,
  parameter int TRCD     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                activate,
  input  logic                precharge,
  input  logic [ROW_BITS-1:0] row_in,
  input  logic                ap_load,
  input  logic                ap_val,
  input  logic                burst_end,
  output logic                is_open,
  output logic [ROW_BITS-1:0] row,
  output logic                trcd_busy
);

  localparam int CW = (TRCD > 1) ? $clog2(TRCD) : 1;

  logic [CW-1:0] trcd_cnt;
  logic          ap_pending;
  logic          ap_now;

  // A burst starting on this edge replaces whatever auto-precharge was pending.
  assign ap_now    = ap_load ? ap_val : ap_pending;
  assign trcd_busy = (trcd_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      is_open    <= 1'b0;
      row        <= '0;
      trcd_cnt   <= '0;
      ap_pending <= 1'b0;
    end else if (activate) begin
      is_open    <= 1'b1;
      row        <= row_in;
      trcd_cnt   <= CW'(TRCD - 1);
      ap_pending <= 1'b0;
    end else begin
      if (trcd_busy) trcd_cnt <= trcd_cnt - CW'(1);
      if (precharge) begin
        is_open    <= 1'b0;
        ap_pending <= 1'b0;
      end else if (burst_end && ap_now) begin
        is_open    <= 1'b0;
        ap_pending <= 1'b0;
      end else if (ap_load) begin
        ap_pending <= ap_val;
      end
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// Chip-side SDRAM emulator: decodes the command bus, tracks banks and mode,
// and serves bursts from internal RAM with CAS-latency timing.
module sdram_responder #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 5,
  parameter int TRCD     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cke,
  input  logic        ncs,
  input  logic        nras,
  input  logic        ncas,
  input  logic        nwe,
  input  logic [1:0]  ba,
  input  logic [12:0] a,
  input  logic        dqml,
  input  logic        dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [4:0]  err,
  output logic [15:0] refresh_cnt
);
  import sdram_pkg::*;

  localparam int AW = 2 + ROW_BITS + COL_BITS;

  logic [15:0] mem [2**AW];

  logic [9:0]  mode;
  logic        mode_valid;
  logic        mode_ok, cl3;
  logic [2:0]  rd_mask, wr_mask, new_mask;

  logic [3:0]  cmd;
  logic        gated, is_rw, rw_ok, new_rd, new_wr, new_rw;
  logic [ERR_W-1:0] err_set;

  logic [3:0]  bank_open, bank_busy, act, pre, ap_load, burst_end;
  logic [ROW_BITS-1:0] bank_row [4];

  logic                burst_active, burst_write;
  logic [1:0]          burst_ba;
  logic [ROW_BITS-1:0] burst_row;
  logic [COL_BITS-1:0] burst_col;
  logic [2:0]          burst_left, burst_mask;
  logic stop_rd, stop_wr, cont_rd, cont_wr, end_old, rd_fire, wr_fire;
  logic [AW-1:0] acc_addr;

  logic        p0_v, p1_v;
  logic [15:0] p0_d, p1_d;

  logic unused_ok;
  assign unused_ok = ^{a[12:11], mode[8:7]};

  function automatic logic [COL_BITS-1:0] next_col(input logic [COL_BITS-1:0] col,
                                                   input logic [2:0] mask);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(mask);
    return (col & ~m) | ((col + COL_BITS'(1)) & m);
  endfunction

  // An unsupported mode is kept but behaves as CL2, BL1.
  assign mode_ok  = mode_supported(mode);
  assign cl3      = mode_ok && (mode[MODE_CL_LSB +: 3] == 3'd3);
  assign rd_mask  = mode_ok ? bl_mask(mode[MODE_BL_LSB +: 3]) : 3'd0;
  assign wr_mask  = mode[MODE_WBS_BIT] ? 3'd0 : rd_mask;

  assign cmd      = (cke && !ncs) ? {1'b0, nras, ncas, nwe} : CMD_NOP;
  assign gated    = !mode_valid && cmd != CMD_NOP && cmd != CMD_LOAD_MODE
                    && cmd != CMD_PRECHARGE;
  assign is_rw    = !gated && (cmd == CMD_READ || cmd == CMD_WRITE);
  assign rw_ok    = is_rw && bank_open[ba];
  assign new_rd   = rw_ok && cmd == CMD_READ;
  assign new_wr   = rw_ok && cmd == CMD_WRITE;
  assign new_rw   = new_rd || new_wr;
  assign new_mask = (cmd == CMD_WRITE) ? wr_mask : rd_mask;

  always_comb begin
    err_set = '0;
    err_set[ERR_NO_MODE]     = gated;
    err_set[ERR_IDLE_ACCESS] = is_rw && !bank_open[ba];
    err_set[ERR_TRCD]        = rw_ok && bank_busy[ba];
    err_set[ERR_BAD_MODE]    = (cmd == CMD_LOAD_MODE) && !mode_supported(a[9:0]);
    err_set[ERR_BANK_STATE]  = ((cmd == CMD_LOAD_MODE) && |bank_open)
                             || (!gated && cmd == CMD_ACTIVE && bank_open[ba])
                             || (!gated && cmd == CMD_REFRESH && |bank_open);
  end

  // Read bursts stop on WRITE/BST and restart on READ; write bursts end on any command.
  assign stop_rd  = burst_active && !burst_write
                    && (cmd == CMD_WRITE || cmd == CMD_BST || new_rd);
  assign stop_wr  = burst_active && burst_write && cmd != CMD_NOP;
  assign cont_rd  = burst_active && !burst_write && !stop_rd;
  assign cont_wr  = burst_active && burst_write && !stop_wr;
  assign end_old  = stop_rd || stop_wr || ((cont_rd || cont_wr) && burst_left == 3'd1);
  assign rd_fire  = !reset && (new_rd || cont_rd);
  assign wr_fire  = !reset && (new_wr || cont_wr);
  assign acc_addr = new_rw ? {ba, bank_row[ba], a[COL_BITS-1:0]}
                           : {burst_ba, burst_row, burst_col};

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      act[b]       = !gated && cmd == CMD_ACTIVE && ba == 2'(b);
      pre[b]       = cmd == CMD_PRECHARGE && (a[10] || ba == 2'(b));
      ap_load[b]   = new_rw && ba == 2'(b);
      burst_end[b] = (end_old && burst_ba == 2'(b) && !ap_load[b])
                   || (ap_load[b] && new_mask == 3'd0);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    sdram_resp_bank #(.ROW_BITS(ROW_BITS), .TRCD(TRCD)) u_bank (
      .clk       (clk),
      .reset     (reset),
      .activate  (act[g]),
      .precharge (pre[g]),
      .row_in    (a[ROW_BITS-1:0]),
      .ap_load   (ap_load[g]),
      .ap_val    (a[10]),
      .burst_end (burst_end[g]),
      .is_open   (bank_open[g]),
      .row       (bank_row[g]),
      .trcd_busy (bank_busy[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode        <= '0;
      mode_valid  <= 1'b0;
      err         <= '0;
      refresh_cnt <= '0;
    end else begin
      if (cmd == CMD_LOAD_MODE) begin
        mode       <= a[9:0];
        mode_valid <= 1'b1;
      end
      if (!gated && cmd == CMD_REFRESH) refresh_cnt <= refresh_cnt + 16'd1;
      err <= err | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_active <= 1'b0;
      burst_write  <= 1'b0;
      burst_ba     <= '0;
      burst_row    <= '0;
      burst_col    <= '0;
      burst_left   <= '0;
      burst_mask   <= '0;
    end else if (new_rw) begin
      burst_active <= (new_mask != 3'd0);
      burst_write  <= new_wr;
      burst_ba     <= ba;
      burst_row    <= bank_row[ba];
      burst_col    <= next_col(a[COL_BITS-1:0], new_mask);
      burst_left   <= new_mask;
      burst_mask   <= new_mask;
    end else if (cont_rd || cont_wr) begin
      burst_col    <= next_col(burst_col, burst_mask);
      burst_left   <= burst_left - 3'd1;
      if (burst_left == 3'd1) burst_active <= 1'b0;
    end else if (stop_rd || stop_wr) begin
      burst_active <= 1'b0;
    end
  end

  // Array access has no reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    if (wr_fire && !dqml) mem[acc_addr][7:0]  <= dq_in[7:0];
    if (wr_fire && !dqmh) mem[acc_addr][15:8] <= dq_in[15:8];
    p0_d <= mem[acc_addr];
    p1_d <= p0_d;
  end

  // RAM read is the first latency stage; CL3 adds one more before the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0_v   <= 1'b0;
      p1_v   <= 1'b0;
      dq_oe  <= 1'b0;
      dq_out <= '0;
    end else begin
      p0_v   <= rd_fire;
      p1_v   <= p0_v;
      dq_oe  <= cl3 ? p1_v : p0_v;
      dq_out <= (cl3 ? p1_v : p0_v) ? (cl3 ? p1_d : p0_d) : 16'h0000;
    end
  end

endmodule
